fb_scanout_reader: RTL and testbench

//  Reader side of the framebuffer burst interface. The draw unit writes pixels into SDRAM banks;

---
 rtl/fb_scanout_reader.sv | 184 ++++++++++++++++++
 tb/tb_fb_scanout_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout_reader.sv
// rtl/fb_scanout_reader.sv - framebuffer scanout reader: SDRAM read bursts into a pixel FIFO
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   frame_start, bank              start a new frame from the given bank (bank sampled on the pulse)
//   read_burst_req/addr/len        burst request towards the SDRAM controller
//   read_burst_data_valid/data     returned pixels, one per valid cycle
//   read_burst_finish              end-of-burst pulse from the controller
//   pixel_rd_en, pixel_data        display pop, data registered one cycle after the pop
//   fifo_empty                     FIFO holds no pixels
//   frame_done                     whole frame requested and received
//   underflow                      sticky pop-while-empty flag, cleared by frame_start
module fb_scanout_reader #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int BURST_LEN  = 64,
   parameter int BURST_BITS = 10,
   parameter int FIFO_DEPTH = 512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic [1:0]            bank,
   output logic                  read_burst_req,
   output logic [23:0]           read_addr,
   output logic [BURST_BITS-1:0] read_burst_len,
   input  logic                  read_burst_data_valid,
   input  logic [15:0]           read_burst_data,
   input  logic                  read_burst_finish,
   input  logic                  pixel_rd_en,
   output logic [15:0]           pixel_data,
   output logic                  fifo_empty,
   output logic                  frame_done,
   output logic                  underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam logic [21:0]   TOTAL_PIX   = 22'(H_ACTIVE * V_ACTIVE);
   localparam logic [21:0]   BURST_IDX   = 22'(BURST_LEN);
   localparam logic [AW:0]   DEPTH_OCC   = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   BURST_OCC   = (AW+1)'(BURST_LEN);
   localparam logic [BW-1:0] BURST_BEATS = BW'(BURST_LEN);

   typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, DATA, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [1:0]    bank_r;
   logic [21:0]   pixel_index;
   logic [21:0]   index_nxt;
   logic          drain_req;
   logic [BW-1:0] beat_cnt;

   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   occupancy;

   logic push, pop_ok, restart, bank_load, advance, start_burst, drain_set;
   logic space_ok, beat_ok;

   assign index_nxt      = pixel_index + BURST_IDX;
   assign space_ok       = (DEPTH_OCC - occupancy) >= BURST_OCC;
   // Beats past BURST_LEN in one burst are dropped; the full check is a backstop only.
   assign beat_ok        = read_burst_data_valid && (beat_cnt < BURST_BEATS) && (occupancy != DEPTH_OCC);
   assign pop_ok         = pixel_rd_en && !fifo_empty;
   assign fifo_empty     = (occupancy == '0);
   assign frame_done     = (state == DONE);
   assign read_burst_len = BURST_BITS'(BURST_LEN);
   // A burst cannot be aborted: after a restart from REQ the request stays up until the
   // controller answers, and everything it returns is thrown away in DRAIN.
   assign read_burst_req = (state == REQ) || ((state == DRAIN) && drain_req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      push        = 1'b0;
      restart     = 1'b0;
      bank_load   = 1'b0;
      advance     = 1'b0;
      start_burst = 1'b0;
      drain_set   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (frame_start) begin
               restart   = 1'b1;
               bank_load = 1'b1;
               state_nxt = WAIT_SPACE;
            end
         end
         WAIT_SPACE: begin
            if (frame_start) begin
               restart   = 1'b1;
               bank_load = 1'b1;
            end else if (space_ok) begin
               start_burst = 1'b1;
               state_nxt   = REQ;
            end
         end
         REQ, DATA: begin
            if (frame_start) begin
               bank_load = 1'b1;
               if (read_burst_finish) begin
                  restart   = 1'b1;
                  state_nxt = WAIT_SPACE;
               end else begin
                  state_nxt = DRAIN;
                  drain_set = (state == REQ) && !read_burst_data_valid;
               end
            end else begin
               push = beat_ok;
               if (read_burst_finish) begin
                  advance   = 1'b1;
                  state_nxt = (index_nxt == TOTAL_PIX) ? DONE : WAIT_SPACE;
               end else if (read_burst_data_valid) begin
                  state_nxt = DATA;
               end
            end
         end
         DRAIN: begin
            bank_load = frame_start;
            if (read_burst_finish) begin
               restart   = 1'b1;
               state_nxt = WAIT_SPACE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_r      <= 2'b00;
         pixel_index <= '0;
         read_addr   <= '0;
         drain_req   <= 1'b0;
         beat_cnt    <= '0;
      end else begin
         if (bank_load) bank_r <= bank;
         if (restart)      pixel_index <= '0;
         else if (advance) pixel_index <= index_nxt;
         // Address is captured once per burst so it cannot move while the request is up.
         if (start_burst) read_addr <= {bank_r, pixel_index};
         if (start_burst) beat_cnt <= '0;
         else if (push)   beat_cnt <= beat_cnt + 1'b1;
         if (drain_set) drain_req <= 1'b1;
         else if (read_burst_data_valid || read_burst_finish || restart) drain_req <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= read_burst_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         pixel_data <= 16'h0000;
         underflow  <= 1'b0;
      end else begin
         if (pixel_rd_en) pixel_data <= fifo_empty ? 16'h0000 : mem[rd_ptr];
         if (restart) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
         end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
               2'b10:   occupancy <= occupancy + 1'b1;
               2'b01:   occupancy <= occupancy - 1'b1;
               default: ;
            endcase
         end
         if (restart)                         underflow <= 1'b0;
         else if (pixel_rd_en && fifo_empty) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb/tb_fb_scanout_reader.sv - directed bench for fb_scanout_reader with a small SDRAM burst model
module tb_fb_scanout_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic [1:0]  bank;
   logic        read_burst_req;
   logic [23:0] read_addr;
   logic [9:0]  read_burst_len;
   logic        read_burst_data_valid;
   logic [15:0] read_burst_data;
   logic        read_burst_finish;
   logic        pixel_rd_en;
   logic [15:0] pixel_data;
   logic        fifo_empty;
   logic        frame_done;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   logic        model_en;
   int          mstep;
   int          bursts;
   int          beats;
   logic [23:0] maddr;
   logic [7:0]  lo;
   logic [23:0] addr_log [16];

   int popped, b0, nb, b1;

   always #5 clk = ~clk;

   fb_scanout_reader #(
      .H_ACTIVE(8), .V_ACTIVE(2), .BURST_LEN(4), .BURST_BITS(10), .FIFO_DEPTH(8)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bank(bank),
      .read_burst_req(read_burst_req), .read_addr(read_addr), .read_burst_len(read_burst_len),
      .read_burst_data_valid(read_burst_data_valid), .read_burst_data(read_burst_data),
      .read_burst_finish(read_burst_finish), .pixel_rd_en(pixel_rd_en), .pixel_data(pixel_data),
      .fifo_empty(fifo_empty), .frame_done(frame_done), .underflow(underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " req"},       32'(read_burst_req), 32'd0);
      check({tag, " addr"},      32'(read_addr),      32'd0);
      check({tag, " pixel"},     32'(pixel_data),     32'd0);
      check({tag, " empty"},     32'(fifo_empty),     32'd1);
      check({tag, " done"},      32'(frame_done),     32'd0);
      check({tag, " underflow"}, 32'(underflow),      32'd0);
   endtask

   // SDRAM model: one cycle after seeing a request, 4 beats then a finish pulse.
   // Pixel value for address A, beat k: {A[23:22], 6'h15, A[7:0]+k}.
   initial begin
      read_burst_data_valid = 1'b0;
      read_burst_finish     = 1'b0;
      read_burst_data       = 16'h0000;
      mstep = 0; bursts = 0; beats = 0; maddr = '0;
      forever begin
         @(negedge clk);
         read_burst_data_valid = 1'b0;
         read_burst_finish     = 1'b0;
         if (!rst_n || !model_en) begin
            mstep = 0;
         end else if (mstep == 0) begin
            if (read_burst_req) begin
               maddr = read_addr;
               if (bursts < 16) addr_log[bursts] = read_addr;
               bursts++;
               mstep = 1;
            end
         end else if (mstep <= 4) begin
            lo = maddr[7:0] + 8'(mstep - 1);
            read_burst_data       = {maddr[23:22], 6'h15, lo};
            read_burst_data_valid = 1'b1;
            beats++;
            mstep++;
         end else begin
            read_burst_finish = 1'b1;
            mstep = 0;
         end
      end
   end

   initial begin
      rst_n = 1'b0; frame_start = 1'b0; bank = 2'd0; pixel_rd_en = 1'b0; model_en = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      check("burst_len", 32'(read_burst_len), 32'd4);
      rst_n = 1'b1;
      model_en = 1'b1;

      // Frame from bank 2 with no pops: FIFO of 8 takes exactly two bursts.
      @(negedge clk); bank = 2'd2; frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
      repeat (40) @(negedge clk);
      check("stall bursts",  32'(bursts),          32'd2);
      check("stall req",     32'(read_burst_req),  32'd0);
      check("addr0",         32'(addr_log[0]),     32'h800000);
      check("addr1",         32'(addr_log[1]),     32'h800004);
      check("stall done",    32'(frame_done),      32'd0);
      check("stall empty",   32'(fifo_empty),      32'd0);

      // Four pops free room for the third burst.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); pixel_rd_en = 1'b1;
         @(posedge clk); #1;
         check("pop first4", 32'(pixel_data), 32'h9500 + 32'(i));
      end
      @(negedge clk); pixel_rd_en = 1'b0;
      repeat (20) @(negedge clk);
      check("third bursts", 32'(bursts),      32'd3);
      check("addr2",        32'(addr_log[2]), 32'h800008);

      // Drain the rest whenever the FIFO has data.
      popped = 4;
      for (int c = 0; c < 300 && popped < 16; c++) begin
         @(negedge clk);
         if (!fifo_empty) begin
            pixel_rd_en = 1'b1;
            @(posedge clk); #1;
            check("pop rest", 32'(pixel_data), 32'h9500 + 32'(popped));
            popped++;
         end else begin
            pixel_rd_en = 1'b0;
         end
      end
      @(negedge clk); pixel_rd_en = 1'b0;
      check("popped count", 32'(popped), 32'd16);
      for (int c = 0; c < 50 && !frame_done; c++) @(negedge clk);
      check("frame_done",     32'(frame_done),     32'd1);
      check("end empty",      32'(fifo_empty),     32'd1);
      check("end underflow",  32'(underflow),      32'd0);
      check("end bursts",     32'(bursts),         32'd4);
      check("addr3",          32'(addr_log[3]),    32'h80000C);
      check("end req",        32'(read_burst_req), 32'd0);

      // Pop while empty.
      @(negedge clk); pixel_rd_en = 1'b1;
      @(posedge clk); #1;
      check("empty pop data", 32'(pixel_data), 32'h0000);
      check("underflow set",  32'(underflow),  32'd1);
      @(negedge clk); pixel_rd_en = 1'b0;

      // New frame from bank 2, restarted to bank 1 after two beats of its first burst.
      b0 = beats; nb = bursts;
      @(negedge clk); bank = 2'd2; frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
      check("underflow clr", 32'(underflow),  32'd0);
      check("done clr",      32'(frame_done), 32'd0);
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (beats >= b0 + 2) break;
      end
      check("two beats", 32'(beats), 32'(b0 + 2));
      @(negedge clk); bank = 2'd1; frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0; bank = 2'd3;
      repeat (40) @(negedge clk);
      check("restart bursts", 32'(bursts),           32'(nb + 3));
      check("killed addr",    32'(addr_log[nb]),     32'h800000);
      check("restart addr",   32'(addr_log[nb + 1]), 32'h400000);
      check("restart addr2",  32'(addr_log[nb + 2]), 32'h400004);
      model_en = 1'b0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk); pixel_rd_en = 1'b1;
         @(posedge clk); #1;
         check("new frame pop", 32'(pixel_data), 32'h5500 + 32'(i));
      end
      @(negedge clk); pixel_rd_en = 1'b0;
      repeat (3) @(negedge clk);
      check("held req",  32'(read_burst_req),  32'd1);
      check("held addr", 32'(read_addr),       32'h400008);
      check("occ 2",     32'(u_dut.occupancy), 32'd2);

      // One beat in takes occupancy to 3; next beat with a pop keeps it at 3.
      model_en = 1'b1;
      b1 = beats;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (beats >= b1 + 1) break;
      end
      check("occ 3",         32'(u_dut.occupancy), 32'd3);
      @(negedge clk); pixel_rd_en = 1'b1;
      @(posedge clk); #1;
      check("occ push+pop",  32'(u_dut.occupancy), 32'd3);
      check("push+pop data", 32'(pixel_data),      32'h5506);
      check("data req low",  32'(read_burst_req),  32'd0);
      @(negedge clk); pixel_rd_en = 1'b0; rst_n = 1'b0;
      #1;
      check_reset_values("mid-burst reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
